// File: rtl/num_disp_pkg.sv
// num_disp_pkg: shared glyph geometry, digit type and ROM address sizing for the numeric overlay
package num_disp_pkg;
  localparam int GLYPHS = 10;
  localparam int X_W = 12;
  localparam int Y_W = 11;
  localparam int PIX_W = 12;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BLANK = 4'hF;
  function automatic int rom_aw(input int w, input int h);
    return $clog2(GLYPHS * w * h);
  endfunction
endpackage

// File: rtl/num_field_hit.sv
// num_field_hit: rectangle test for one field and pixel position relative to its top-left corner
module num_field_hit
  import num_disp_pkg::*;
#(
  parameter int W = 256,
  parameter int H = 32,
  parameter int LXW = 8,
  parameter int LYW = 5
)(
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] fx,
  input  logic [Y_W-1:0] fy,
  output logic           hit,
  output logic [LXW-1:0] lx,
  output logic [LYW-1:0] ly
);
  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;
  // lower bound is checked before the difference is trusted, so fields near the edge never wrap
  assign dx = x - fx;
  assign dy = y - fy;
  assign hit = x >= fx && y >= fy && 32'(dx) < W && 32'(dy) < H;
  assign lx = dx[LXW-1:0];
  assign ly = dy[LYW-1:0];
endmodule

// File: rtl/num_field_renderer.sv
// num_field_renderer: multi-field BCD overlay sharing one glyph ROM, fixed 3+ROM_LAT cycle latency
module num_field_renderer
  import num_disp_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int DIGITS = 8,
  parameter int DIGIT_W = 32,
  parameter int DIGIT_H = 32,
  parameter int ROM_LAT = 2,
  parameter int BLINK_PERIOD = 30,
  parameter logic [PIX_W-1:0] NUM_COLOR = 12'hFFF
)(
  input  logic                              clk_in,
  input  logic                              rstn_in,
  input  logic [X_W-1:0]                    hcount_in,
  input  logic [Y_W-1:0]                    vcount_in,
  input  logic                              frame_start_in,
  input  logic [X_W*NUM_FIELDS-1:0]         field_x_in,
  input  logic [Y_W*NUM_FIELDS-1:0]         field_y_in,
  input  logic [PIX_W*NUM_FIELDS-1:0]       field_color_in,
  input  logic [4*DIGITS*NUM_FIELDS-1:0]    bcd_in,
  input  logic [NUM_FIELDS-1:0]             lz_blank_in,
  input  logic [NUM_FIELDS-1:0]             blink_in,
  output logic [rom_aw(DIGIT_W, DIGIT_H)-1:0] rom_addr_out,
  input  logic                              rom_data_in,
  output logic [PIX_W-1:0]                  pixel_out,
  output logic [NUM_FIELDS-1:0]             field_hit_out
);
  localparam int AW = rom_aw(DIGIT_W, DIGIT_H);
  localparam int LXW = $clog2(DIGITS * DIGIT_W);
  localparam int LYW = $clog2(DIGIT_H);
  localparam int CW = $clog2(DIGIT_W);
  localparam int DIW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int FIW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  localparam int SW = 4 * DIGITS;
  logic [SW*NUM_FIELDS-1:0] bcd_pend, bcd_snap;
  logic [NUM_FIELDS-1:0]    lz_pend, lz_snap;
  logic                     commit, armed, hidden;
  logic [BW-1:0]            blink_cnt;
  logic [X_W-1:0]           s0_x;
  logic [Y_W-1:0]           s0_y;
  logic                     s0_v;
  logic [NUM_FIELDS-1:0]    hit;
  logic [LXW-1:0]           lx [NUM_FIELDS];
  logic [LYW-1:0]           ly [NUM_FIELDS];
  logic [FIW-1:0]           win;
  logic [NUM_FIELDS-1:0]    win_oh;
  logic                     s1_v;
  logic [NUM_FIELDS-1:0]    s1_oh;
  logic [FIW-1:0]           s1_f;
  logic [LXW-1:0]           s1_lx;
  logic [LYW-1:0]           s1_ly;
  logic [DIW-1:0]           s1_di;
  logic [CW-1:0]            s1_cx;
  logic [SW-1:0]            s1_bcd;
  logic                     s1_lead, s1_draw;
  bcd_digit_t               s1_dig;
  logic [PIX_W-1:0]         s1_col_raw, s1_col;
  logic [ROM_LAT:0]         sb_draw;
  logic [NUM_FIELDS-1:0]    sb_hit [ROM_LAT+1];
  logic [PIX_W-1:0]         sb_col [ROM_LAT+1];
  // Snapshot is captured on the pulse and committed one cycle later, so a pixel
  // already past S0 when frame_start arrives still renders from the old frame.
  always_ff @(posedge clk_in or negedge rstn_in)
    if (!rstn_in) begin
      bcd_pend <= '0;
      lz_pend <= '0;
      bcd_snap <= '0;
      lz_snap <= '0;
      commit <= 1'b0;
      armed <= 1'b0;
      hidden <= 1'b0;
      blink_cnt <= '0;
    end else begin
      commit <= frame_start_in;
      if (frame_start_in) begin
        bcd_pend <= bcd_in;
        lz_pend <= lz_blank_in;
        armed <= 1'b1;
      end
      if (commit) begin
        bcd_snap <= bcd_pend;
        lz_snap <= lz_pend;
        blink_cnt <= blink_cnt == BW'(BLINK_PERIOD - 1) ? '0 : blink_cnt + BW'(1);
        hidden <= blink_cnt == BW'(BLINK_PERIOD - 1) ? ~hidden : hidden;
      end
    end
  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_hit
    num_field_hit #(.W(DIGITS * DIGIT_W), .H(DIGIT_H), .LXW(LXW), .LYW(LYW)) u_hit (
      .x(s0_x),
      .y(s0_y),
      .fx(field_x_in[X_W*i +: X_W]),
      .fy(field_y_in[Y_W*i +: Y_W]),
      .hit(hit[i]),
      .lx(lx[i]),
      .ly(ly[i])
    );
  end
  // scanning from the top down leaves the lowest hitting index as the winner
  always_comb begin
    win = '0;
    win_oh = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--)
      if (hit[i]) begin
        win = FIW'(i);
        win_oh = NUM_FIELDS'(1) << i;
      end
  end
  assign s1_di = DIW'(DIGITS - 1) - DIW'(s1_lx >> CW);
  assign s1_cx = s1_lx[CW-1:0];
  assign s1_bcd = bcd_snap[s1_f*SW +: SW];
  always_comb begin
    s1_lead = s1_di != '0 && lz_snap[s1_f];
    for (int k = 0; k < DIGITS; k++)
      if (k >= 32'(s1_di) && s1_bcd[4*k +: 4] != 4'd0) s1_lead = 1'b0;
  end
  assign s1_dig = s1_lead || (blink_in[s1_f] && hidden) ? BLANK : s1_bcd[4*s1_di +: 4];
  assign s1_draw = s1_v && s1_dig <= 4'd9;
  assign s1_col_raw = field_color_in[s1_f*PIX_W +: PIX_W];
  assign s1_col = s1_col_raw == '0 ? NUM_COLOR : s1_col_raw;
  always_ff @(posedge clk_in or negedge rstn_in)
    if (!rstn_in) begin
      s0_x <= '0;
      s0_y <= '0;
      s0_v <= 1'b0;
      s1_v <= 1'b0;
      s1_oh <= '0;
      s1_f <= '0;
      s1_lx <= '0;
      s1_ly <= '0;
      rom_addr_out <= '0;
      sb_draw <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        sb_hit[i] <= '0;
        sb_col[i] <= '0;
      end
      pixel_out <= '0;
      field_hit_out <= '0;
    end else begin
      s0_x <= hcount_in;
      s0_y <= vcount_in;
      s0_v <= armed | frame_start_in;
      s1_v <= s0_v && |hit;
      s1_oh <= s0_v ? win_oh : '0;
      s1_f <= win;
      s1_lx <= lx[win];
      s1_ly <= ly[win];
      rom_addr_out <= s1_draw ? AW'(32'(s1_dig) * DIGIT_W * DIGIT_H + 32'(s1_ly) * DIGIT_W + 32'(s1_cx)) : '0;
      sb_draw[0] <= s1_draw;
      sb_hit[0] <= s1_oh;
      sb_col[0] <= s1_col;
      for (int i = 1; i <= ROM_LAT; i++) begin
        sb_draw[i] <= sb_draw[i-1];
        sb_hit[i] <= sb_hit[i-1];
        sb_col[i] <= sb_col[i-1];
      end
      pixel_out <= sb_draw[ROM_LAT] && rom_data_in ? sb_col[ROM_LAT] : '0;
      field_hit_out <= sb_hit[ROM_LAT];
    end
endmodule

// File: doc/num_field_renderer.md
Name: num_field_renderer

Overview:
- Generalised numeric overlay renderer. Draws NUM_FIELDS independent BCD fields (score, level, lines, and later extras such as high score) from one shared digit-glyph ROM.
- Takes a single raw pixel position. All hcount delay matching is internal, and there is a fixed, documented pipeline latency.
- Adds three features: frame-synchronous value snapshot (no tearing), per-field leading-zero blanking, and per-field blink.
- Output feeds the video mixer, which uses it in place of per-field pixel buses.

Parameters:
NUM_FIELDS, 3, number of independent numeric fields
DIGITS, 8, BCD digits per field (bcd width = 4*DIGITS)
DIGIT_W, 32, glyph width in pixels (power of 2)
DIGIT_H, 32, glyph height in pixels
ROM_LAT, 2, glyph ROM read latency in cycles
BLINK_PERIOD, 30, frames per blink half-period
NUM_COLOR, 12'hFFF, default glyph colour when field colour is 0

Ports:
clk_in  in  1  pixel clock
rstn_in  in  1  asynchronous active-low reset
hcount_in  in  12  current pixel x
vcount_in  in  11  current pixel y
frame_start_in  in  1  one-cycle pulse at start of frame (before first active pixel)
field_x_in  in  12*NUM_FIELDS  left edge per field, field i at [12i+:12]
field_y_in  in  11*NUM_FIELDS  top edge per field
field_color_in  in  12*NUM_FIELDS  glyph colour per field; 0 selects NUM_COLOR
bcd_in  in  4*DIGITS*NUM_FIELDS  live BCD values, digit 0 = least significant
lz_blank_in  in  NUM_FIELDS  leading-zero blanking enable per field
blink_in  in  NUM_FIELDS  blink enable per field
rom_addr_out  out  log2(10*DIGIT_W*DIGIT_H)  glyph ROM address
rom_data_in  in  1  glyph ROM pixel, valid ROM_LAT cycles after address
pixel_out  out  12  rendered colour, 0 when no glyph pixel
field_hit_out  out  NUM_FIELDS  one-hot field owning pixel_out, 0 when none

Behaviour:
- Reset (async, rstn_in=0): pixel_out=0, field_hit_out=0, rom_addr_out=0, snapshot registers=0, blink counter=0, blink phase=visible. All pipeline valid bits are cleared.
- Snapshot: on frame_start_in, copy bcd_in and lz_blank_in into shadow registers. Rendering uses only the shadow copies. A value change mid-frame takes effect from the next frame.
- Blink: an internal frame counter counts frame_start_in pulses and wraps at BLINK_PERIOD-1, toggling the phase. When blink_in[i]=1 and the phase is hidden, field i renders as fully blank but still claims field_hit_out.
- S0 (cycle 0): register hcount/vcount. For each field compute hit = x in [fx, fx+DIGITS*DIGIT_W) and y in [fy, fy+DIGIT_H). Comparisons are unsigned and range-checked before subtraction, so there is no wrap-around hit. The lowest field index wins on overlap.
- S1 (cycle 1): local_x/local_y relative to the winning field; digit_index = DIGITS-1 - local_x/DIGIT_W; col = local_x mod DIGIT_W.
- S1 also computes the leading-zero mask per field from the snapshot: digit k is blank if lz_blank is set, all digits above and including k are 0, and k != 0. The least significant digit is always drawn.
- Invalid digit (>9): blank.
- S2 (cycle 2): rom_addr_out = digit_value*DIGIT_W*DIGIT_H + local_y*DIGIT_W + col. Drive 0 when blank or no hit.
- A blank/hit/colour side-band is delayed ROM_LAT cycles alongside the ROM read.
- Output (cycle 3+ROM_LAT, i.e. 5 at default): pixel_out = colour if hit and not blank and rom_data_in=1, else 0. field_hit_out is registered at the same time.
- Fixed latency: pixel_out corresponds to the hcount_in presented 3+ROM_LAT cycles earlier. The mixer delays its other layers to match.
- frame_start_in coinciding with an active pixel: the snapshot updates, and pixels already in the pipeline use the old values.
- Reset mid-frame clears everything. Rendering resumes on the next frame_start_in with zero values.

Decomposition:
- Package num_disp_pkg: glyph geometry constants, the ROM address width function (clog2), the BCD digit typedef (logic [3:0]), and the BLANK digit code.
- Sub-module num_field_hit: per-field rectangle test plus local coordinate computation, instantiated NUM_FIELDS times in a generate loop.
- The priority select lives in the top module.

Test Plan:
- Reset, then field0 at (464,514), bcd 32'h00001234, lz off, frame pulse, scan (464,514) → rom_addr_out = 0 at cycle 2. At (688,514), digit 4 → rom_addr_out = 4096 at cycle 2 and pixel_out = 12'hFFF at cycle 5 when ROM returns 1.
- lz_blank_in[0]=1, bcd 32'h00000507: pixels for digits 7..3 → pixel_out=0, rom_addr_out=0. Digit 2 ('5') and digit 1 ('0') are drawn. All-zero value still draws the single '0' at digit 0.
- Change bcd_in mid-frame from 32'h11111111 to 32'h22222222 → addresses stay in the '1' glyph range (1024..2047) until the next frame_start_in, then the '2' range.
- Fields 0 and 1 overlap at (470,520) → field_hit_out=3'b001 and field 0 colour is used.
- blink_in[2]=1, BLINK_PERIOD=2: pixel_out for field 2 is visible for 2 frames then 0 for 2 frames, while field_hit_out[2] stays 1.
- Assert rstn_in low asynchronously mid-line → pixel_out and field_hit_out are 0 immediately. After release, output stays 0 until a frame_start_in.
